// File: rtl/vc_mem_req_arb2.sv
// Two-client memory request arbiter with in-order response routing through a small ID FIFO.
// Define VC_MEM_ARB_FIXED_PRIORITY_EN for fixed priority (client 0 wins); default is round-robin.

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + $clog2((d_)/8) + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1 + $clog2((d_)/8) + (d_))
`endif

module vc_mem_req_arb2 #(
    parameter int p_addr_sz      = 8,
    parameter int p_data_sz      = 32,
    parameter int p_max_inflight = 4,
    localparam int c_req_msg_sz  = `VC_MEM_REQ_MSG_SZ(p_addr_sz, p_data_sz),
    localparam int c_resp_msg_sz = `VC_MEM_RESP_MSG_SZ(p_data_sz)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic [c_req_msg_sz-1:0]  req0_msg,

    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic [c_req_msg_sz-1:0]  req1_msg,

    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    output logic [c_req_msg_sz-1:0]  memreq_msg,

    input  logic                     memresp_val,
    output logic                     memresp_rdy,
    input  logic [c_resp_msg_sz-1:0] memresp_msg,

    output logic                     resp0_val,
    input  logic                     resp0_rdy,
    output logic [c_resp_msg_sz-1:0] resp0_msg,

    output logic                     resp1_val,
    input  logic                     resp1_rdy,
    output logic [c_resp_msg_sz-1:0] resp1_msg
);

    localparam int c_ptr_sz = $clog2(p_max_inflight);
    localparam logic [c_ptr_sz:0] c_count_full = (c_ptr_sz + 1)'(p_max_inflight);

    logic [p_max_inflight-1:0] r_ids;
    logic [c_ptr_sz-1:0]       r_head;
    logic [c_ptr_sz-1:0]       r_tail;
    logic [c_ptr_sz:0]         r_count;

    logic w_full;
    logic w_empty;
    logic w_grant;
    logic w_head_id;
    logic w_push;
    logic w_pop;

    assign w_full    = (r_count == c_count_full);
    assign w_empty   = (r_count == '0);
    assign w_head_id = r_ids[r_head];

`ifdef VC_MEM_ARB_FIXED_PRIORITY_EN
    assign w_grant = ~req0_val;
`else
    logic r_prio;

    always_comb begin
        w_grant = r_prio;
        if (req0_val && !req1_val)
            w_grant = 1'b0;
        else if (req1_val && !req0_val)
            w_grant = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_prio <= 1'b0;
        else if (w_push)
            r_prio <= ~w_grant;
    end
`endif

    // Full is judged on the registered count so a same-cycle pop never admits a push.
    assign memreq_val = (req0_val | req1_val) & ~w_full;
    assign memreq_msg = w_grant ? req1_msg : req0_msg;
    assign req0_rdy   = ~w_grant & memreq_rdy & ~w_full;
    assign req1_rdy   =  w_grant & memreq_rdy & ~w_full;
    assign w_push     = memreq_val & memreq_rdy;

    assign resp0_val   = ~w_empty & ~w_head_id & memresp_val;
    assign resp1_val   = ~w_empty &  w_head_id & memresp_val;
    assign memresp_rdy = ~w_empty & (w_head_id ? resp1_rdy : resp0_rdy);
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign w_pop       = memresp_val & memresp_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ids   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_ids[r_tail] <= w_grant;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_pop)
                r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_vc_mem_req_arb2.sv
// Directed bench for vc_mem_req_arb2: queue-based arbiter model, bench-side 1-cycle test memory.
`timescale 1ns/1ps

module tb_vc_mem_req_arb2;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int RQW   = 1 + AW + 2 + DW;
    localparam int RSW   = 1 + 2 + DW;

    logic clk = 1'b0;
    logic reset;
    logic req0_val, req0_rdy, req1_val, req1_rdy;
    logic [RQW-1:0] req0_msg, req1_msg, memreq_msg;
    logic memreq_val, memreq_rdy;
    logic memresp_val, memresp_rdy;
    logic [RSW-1:0] memresp_msg, resp0_msg, resp1_msg;
    logic resp0_val, resp0_rdy, resp1_val, resp1_rdy;

    vc_mem_req_arb2 #(.p_addr_sz(AW), .p_data_sz(DW), .p_max_inflight(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg)
    );

    always #5 clk = ~clk;

    // Arbiter model: list of in-flight client IDs in issue order, plus tie-break owner.
    bit       q_ids[$];
    bit       m_prio;
    bit       e_push, e_pop, e_grant;
    // Test memory
    logic [RSW-1:0] mq[$];
    logic [31:0]    mem [256];
    bit             mem_hold, inj;
    logic           s_mfire, s_mpop;
    logic [RQW-1:0] s_mmsg;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [RQW-1:0] rd(logic [7:0] a);
        return {1'b0, a, 2'b00, 32'h0};
    endfunction

    function automatic logic [RQW-1:0] wr(logic [7:0] a, logic [31:0] d);
        return {1'b1, a, 2'b00, d};
    endfunction

    function automatic bit m_grant();
`ifdef VC_MEM_ARB_FIXED_PRIORITY_EN
        return !req0_val;
`else
        if (req0_val && !req1_val) return 1'b0;
        if (req1_val && !req0_val) return 1'b1;
        return m_prio;
`endif
    endfunction

    // Inputs already set; present memory response, then compare on the falling edge.
    task automatic cyc_a();
        bit full, empty, h, e_mv;
        if (reset) begin
            q_ids.delete();
            m_prio = 1'b0;
            mq.delete();
        end
        memresp_val = (!mem_hold && mq.size() > 0) || (inj && mq.size() == 0);
        memresp_msg = (mq.size() > 0) ? mq[0] : {3'b111, 32'h0bad0bad};
        @(negedge clk);
        full    = (q_ids.size() == DEPTH);
        empty   = (q_ids.size() == 0);
        h       = empty ? 1'b0 : q_ids[0];
        e_grant = m_grant();
        e_mv    = (req0_val || req1_val) && !full;
        chk("memreq_val", memreq_val, e_mv);
        if (e_mv) chk("memreq_msg", memreq_msg, e_grant ? req1_msg : req0_msg);
        chk("req0_rdy", req0_rdy, !e_grant && memreq_rdy && !full);
        chk("req1_rdy", req1_rdy, e_grant && memreq_rdy && !full);
        chk("resp0_val", resp0_val, !empty && !h && memresp_val);
        chk("resp1_val", resp1_val, !empty && h && memresp_val);
        chk("memresp_rdy", memresp_rdy, !empty && (h ? resp1_rdy : resp0_rdy));
        chk("resp0_msg", resp0_msg, memresp_msg);
        chk("resp1_msg", resp1_msg, memresp_msg);
        e_push  = e_mv && memreq_rdy;
        e_pop   = !empty && memresp_val && (h ? resp1_rdy : resp0_rdy);
        s_mfire = memreq_val && memreq_rdy;
        s_mmsg  = memreq_msg;
        s_mpop  = memresp_val && memresp_rdy;
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) begin
            if (e_pop)  void'(q_ids.pop_front());
            if (e_push) begin
                q_ids.push_back(e_grant);
                m_prio = !e_grant;
            end
            if (s_mpop && mq.size() > 0) void'(mq.pop_front());
            if (s_mfire) begin
                if (s_mmsg[RQW-1]) begin
                    mem[s_mmsg[RQW-2 -: 8]] = s_mmsg[31:0];
                    mq.push_back({1'b1, 2'b00, 32'h0});
                end else begin
                    mq.push_back({1'b0, 2'b00, mem[s_mmsg[RQW-2 -: 8]]});
                end
            end
        end
        #1;
    endtask

    task automatic cycle();
        cyc_a();
        advance();
    endtask

    task automatic set_req(bit v0, logic [RQW-1:0] m0, bit v1, logic [RQW-1:0] m1);
        req0_val = v0; req0_msg = m0;
        req1_val = v1; req1_msg = m1;
    endtask

    initial begin
        reset = 1'b1; memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        mem_hold = 1'b0; inj = 1'b0;
        memresp_val = 1'b0; memresp_msg = '0;
        set_req(1'b0, '0, 1'b0, '0);
        for (int unsigned i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h00] = 32'h11111111;
        mem[8'h04] = 32'h22222222;
        #1;

        // Reset state: requests pass straight through, client 0 owns the tie.
        set_req(1'b1, rd(8'h00), 1'b1, rd(8'h04));
        cyc_a();
        chk("rst_req0_rdy", req0_rdy, 1'b1);
        chk("rst_req1_rdy", req1_rdy, 1'b0);
        chk("rst_memresp_rdy", memresp_rdy, 1'b0);
        advance();
        set_req(1'b0, '0, 1'b0, '0);
        cycle();
        reset = 1'b0;

        // Client 0 alone: write then read back.
        set_req(1'b1, wr(8'h10, 32'hdeadbeef), 1'b0, '0);
        cycle();
        set_req(1'b1, rd(8'h10), 1'b0, '0);
        cycle();
        set_req(1'b0, '0, 1'b0, '0);
        cyc_a();
        chk("t1_resp0_val", resp0_val, 1'b1);
        chk("t1_resp0_data", resp0_msg[31:0], 32'hdeadbeef);
        chk("t1_resp1_val", resp1_val, 1'b0);
        advance();
        cycle();

        // Fresh reset so the tie-break starts at client 0.
        reset = 1'b1; cycle(); reset = 1'b0;
        set_req(1'b1, rd(8'h00), 1'b1, rd(8'h04));
        memreq_rdy = 1'b0;
        cycle();
        memreq_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc_a();
            if (i == 0) chk("t2_first_msg", memreq_msg, rd(8'h00));
`ifndef VC_MEM_ARB_FIXED_PRIORITY_EN
            if (i == 1) chk("t2_second_msg", memreq_msg, rd(8'h04));
            if (i == 2) chk("t2_resp1_data", resp1_msg[31:0], 32'h22222222);
`endif
            if (i == 1) chk("t2_resp0_data", resp0_msg[31:0], 32'h11111111);
            advance();
        end
        set_req(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle();

        // Fill the ID FIFO with the memory stalled, then release.
        mem_hold = 1'b1;
        set_req(1'b1, rd(8'h00), 1'b1, rd(8'h04));
        for (int i = 0; i < 6; i++) begin
            cyc_a();
            if (i == 4) begin
                chk("t3_full_memreq_val", memreq_val, 1'b0);
                chk("t3_full_req0_rdy", req0_rdy, 1'b0);
                chk("t3_full_req1_rdy", req1_rdy, 1'b0);
            end
            advance();
        end
        mem_hold = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        set_req(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 6; i++) cycle();

        // Head belongs to client 0 which is not ready; client 1 must wait behind it.
        resp0_rdy = 1'b0;
        set_req(1'b1, rd(8'h00), 1'b0, '0);
        cycle();
        set_req(1'b0, '0, 1'b1, rd(8'h04));
        cycle();
        set_req(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            cyc_a();
            chk("t4_memresp_rdy", memresp_rdy, 1'b0);
            chk("t4_resp1_val", resp1_val, 1'b0);
            chk("t4_resp0_val", resp0_val, 1'b1);
            advance();
        end
        resp0_rdy = 1'b1;
        cycle();
        cyc_a();
        chk("t4_resp1_val_late", resp1_val, 1'b1);
        chk("t4_resp1_data", resp1_msg[31:0], 32'h22222222);
        advance();

        // Stray response with nothing in flight is stalled.
        inj = 1'b1;
        cyc_a();
        chk("t5_memresp_rdy", memresp_rdy, 1'b0);
        chk("t5_resp0_val", resp0_val, 1'b0);
        advance();
        inj = 1'b0;
        cycle();

        // Reset with three requests outstanding.
        mem_hold = 1'b1;
        set_req(1'b1, rd(8'h00), 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        set_req(1'b1, rd(8'h00), 1'b1, rd(8'h04));
        cyc_a();
        chk("t6_resp0_val", resp0_val, 1'b0);
        chk("t6_memresp_rdy", memresp_rdy, 1'b0);
        chk("t6_req0_rdy", req0_rdy, 1'b1);
        chk("t6_req1_rdy", req1_rdy, 1'b0);
        advance();
        reset = 1'b0;
        mem_hold = 1'b0;
        cycle();
        set_req(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_mem_req_arb2.md
# vc_mem_req_arb2

Two-requester memory arbiter. It multiplexes request streams from two clients onto one port of the test memory and routes the in-order responses back to the client that issued each request. It sits directly upstream of a test-memory port, so two agents (e.g. instruction and data paths) can share one port. A small ID FIFO tracks in-flight requests.

## Interface

Parameters:
- p_addr_sz, 8, memory request address width in bits
- p_data_sz, 32, memory request/response data width in bits
- p_max_inflight, 4, depth of the ID FIFO (power of two, ≥ 2)
- c_req_msg_sz, `VC_MEM_REQ_MSG_SZ(p_addr_sz,p_data_sz)`, local constant
- c_resp_msg_sz, `VC_MEM_RESP_MSG_SZ(p_data_sz)`, local constant

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- req0_val / req0_rdy / req0_msg  in/out/in  1/1/c_req_msg_sz  client 0 request
- req1_val / req1_rdy / req1_msg  in/out/in  1/1/c_req_msg_sz  client 1 request
- memreq_val / memreq_rdy / memreq_msg  out/in/out  1/1/c_req_msg_sz  request to memory port
- memresp_val / memresp_rdy / memresp_msg  in/out/in  1/1/c_resp_msg_sz  response from memory port
- resp0_val / resp0_rdy / resp0_msg  out/in/out  1/1/c_resp_msg_sz  client 0 response
- resp1_val / resp1_rdy / resp1_msg  out/in/out  1/1/c_resp_msg_sz  client 1 response

## Operation

- State:
  - prio: 1 bit; the client favoured on a tie.
  - ID FIFO: p_max_inflight × 1 bit, with head/tail pointers and an occupancy count of width $clog2(p_max_inflight)+1.
- Grant, combinational:
  - Only req0_val high → 0.
  - Only req1_val high → 1.
  - Both high → prio.
  - Neither high → prio; outputs are don't-care because memreq_val is 0.
- memreq_val = (req0_val | req1_val) & !full.
- memreq_msg = message of the granted client. Messages pass through bit-exact; they are never decoded or modified.
- reqN_rdy = (grant == N) & memreq_rdy & !full. The non-granted client always sees rdy = 0.
- Request fire (memreq_val & memreq_rdy):
  - Push the grant ID at the tail.
  - Set prio to !grant (round-robin).
  - If no request fires, prio holds.
- Full FIFO: memreq_val = 0, both reqN_rdy = 0. A same-cycle pop does NOT free a slot for a push in that cycle.
- Response routing, when the FIFO is non-empty with head ID h:
  - resp_h_val = memresp_val; the other resp_val = 0.
  - memresp_rdy = resp_h_rdy.
  - Both resp0_msg and resp1_msg = memresp_msg unconditionally.
- Response fire (memresp_val & memresp_rdy) pops the head.
- Empty FIFO: memresp_rdy = 0, resp0_val = resp1_val = 0. A memresp_val arriving then is a protocol error; it is stalled, never dropped.
- Simultaneous push and pop (FIFO neither empty nor full): count is unchanged, both pointers advance.
- Pointers wrap modulo p_max_inflight.

## Timing

- Zero added latency: requests and responses pass combinationally in the cycle they are presented. End-to-end latency equals that of the downstream memory.
- No combinational path from any *_rdy input to any *_val output, except resp_val derived from memresp_val.
  - memreq_val depends only on reqN_val and FIFO state.
- Reset (async assert, sync-release behaviour irrelevant):
  - FIFO empty, pointers 0, count 0, prio = 0.
  - memresp_rdy = 0 and respN_val = 0.
  - memreq_val follows reqN_val; req0_rdy follows memreq_rdy, req1_rdy = 0.
- Reset mid-operation: in-flight IDs are discarded. The downstream memory must be reset in the same cycle.
- Full throughput with the 1-cycle test memory needs p_max_inflight ≥ 2.

## Configuration

- VC_MEM_ARB_FIXED_PRIORITY_EN defined:
  - Client 0 always wins on a tie.
  - The prio register is not built; grant = req0_val ? 0 : 1.
- Undefined (default): round-robin arbitration as described above.

## Test plan

- Client 0 alone, write addr 0x10 data 0xdeadbeef then read 0x10, both resp_rdy = 1 → resp0 read data 0xdeadbeef one cycle after issue; resp1_val never asserted.
- Both clients request every cycle; client 0 reads 0x00, client 1 reads 0x04 → memreq alternates 0,1,0,1 starting with client 0 after reset; responses alternate; each client gets one response per 2 cycles.
- Same stimulus with VC_MEM_ARB_FIXED_PRIORITY_EN → only client 0 is granted while req0_val = 1; req1_rdy stays 0.
- p_max_inflight = 2, memory resp_rdy held 0 → after 2 fires memreq_val = 0 and both req rdy = 0. Releasing resp_rdy drains in issue order and reopens requests one cycle later.
- resp0_rdy = 0 while head ID = 0 and client 1 response queued behind → memresp_rdy = 0, resp1_val = 0 until resp0_rdy rises. Ordering is preserved.
- Assert reset with 3 requests in flight → next cycle count = 0, resp0_val = resp1_val = 0, prio = 0.
